// File: rtl/mpu_pkg.sv
// -----------------------------------------------------------------------------
// mpu_pkg
// Shared definitions for the MPU command front end and the execute datapath:
// sequencer state encoding, status LED codes, command word geometry and the
// error display pattern.
// -----------------------------------------------------------------------------
package mpu_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_GET0  = 4'd1,
        ST_GET1  = 4'd2,
        ST_GET2  = 4'd3,
        ST_GET3  = 4'd4,
        ST_ISSUE = 4'd5,
        ST_WAIT  = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } state_t;

    // Status LED codes, bit order {err, done, busy, entering}
    localparam logic [3:0] LED_IDLE  = 4'b0000;
    localparam logic [3:0] LED_ENTER = 4'b0001;
    localparam logic [3:0] LED_BUSY  = 4'b0010;
    localparam logic [3:0] LED_DONE  = 4'b0100;
    localparam logic [3:0] LED_ERR   = 4'b1000;

    // Command word geometry: NIBBLES nibbles, first captured nibble on top
    localparam int NIBBLES    = 4;
    localparam int NIB_W      = 4;
    localparam int CMD_W      = NIBBLES * NIB_W;
    localparam int OPCODE_MSB = CMD_W - 1;
    localparam int OPCODE_LSB = CMD_W - NIB_W;

    // Display pattern shown when the datapath never answered
    localparam logic [7:0] ERR_DISP = 8'hEE;

    // LSB position of command nibble idx (idx 0 is the opcode)
    function automatic int nibble_lsb(input int idx);
        return OPCODE_LSB - (NIB_W * idx);
    endfunction

endpackage

// File: rtl/btn_press_filter.sv
// -----------------------------------------------------------------------------
// btn_press_filter
// Turns a raw, asynchronous push-button into a single-cycle press pulse.
// Two-flop synchronizer, then a saturating count of consecutive high samples.
// The pulse fires when the count reaches DEB_CYCLES; because the count
// saturates, another pulse needs a synchronized low sample first.
//
// Ports:
//   i_clk    in   system clock
//   i_rst    in   asynchronous active-high reset
//   i_btn    in   raw button level (asynchronous to i_clk)
//   o_press  out  registered one-cycle press pulse
// -----------------------------------------------------------------------------
module btn_press_filter #(
    parameter int DEB_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEB_CYCLES);

    logic             r_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Bring the button into the clock domain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    // Stable-high counter with one-shot on reaching DEB_CYCLES
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_press <= 1'b0;
        end else if (!r_sync) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_press <= 1'b0;
        end else if (r_cnt == CNT_FULL) begin
            // Saturated: held button, wait for release before rearming
            r_cnt   <= r_cnt;
            r_press <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_press <= (r_cnt == CNT_LAST);
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/mpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// mpu_cmd_sequencer
// Front-end controller for the MPU datapath. Collects four switch nibbles on
// successive enter presses into a command word, offers it over valid/ready,
// then waits for the result strobe under a watchdog and reports through the
// status LEDs and two display nibbles.
//
// Ports:
//   i_clk        in   system clock
//   i_rst        in   asynchronous active-high reset
//   i_enter      in   raw enter button
//   i_sw         in   switch nibble, captured on an accepted press
//   o_cmd_valid  out  command word valid
//   i_cmd_ready  in   datapath accepts command
//   o_cmd_word   out  {n0,n1,n2,n3}, n0 = opcode
//   i_res_valid  in   one-cycle result strobe
//   i_res_data   in   result byte
//   o_led        out  {err, done, busy, entering}
//   o_disp_hi    out  left display nibble
//   o_disp_lo    out  right display nibble
// -----------------------------------------------------------------------------
module mpu_cmd_sequencer
    import mpu_pkg::*;
#(
    parameter int DEB_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enter,
    input  logic [3:0]       i_sw,
    output logic             o_cmd_valid,
    input  logic             i_cmd_ready,
    output logic [15:0]      o_cmd_word,
    input  logic             i_res_valid,
    input  logic [7:0]       i_res_data,
    output logic [3:0]       o_led,
    output logic [3:0]       o_disp_hi,
    output logic [3:0]       o_disp_lo
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic             w_press;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CMD_W-1:0] r_cmd_word;
    logic [CMD_W-1:0] w_word_nx;
    logic             r_cmd_valid;
    logic             w_valid_nx;
    logic [WD_W-1:0]  r_wdog;
    logic [WD_W-1:0]  w_wdog_nx;
    logic [3:0]       r_led;
    logic [3:0]       w_led_nx;
    logic [3:0]       r_disp_hi;
    logic [3:0]       r_disp_lo;
    logic [7:0]       w_result_nx;
    logic [7:0]       w_disp_nx;

    btn_press_filter #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_enter_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_enter),
        .o_press (w_press)
    );

    // Next state, command capture, watchdog and result latch
    always_comb begin
        w_state_nx  = r_state;
        w_word_nx   = r_cmd_word;
        w_wdog_nx   = r_wdog;
        w_result_nx = {r_disp_hi, r_disp_lo};
        case (r_state)
            ST_IDLE: begin
                w_word_nx = {CMD_W{1'b0}};
                if (w_press) begin
                    w_state_nx = ST_GET0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_GET0: begin
                if (w_press) begin
                    w_word_nx[nibble_lsb(0) +: NIB_W] = i_sw;
                    w_state_nx = ST_GET1;
                end else begin
                    w_state_nx = ST_GET0;
                end
            end
            ST_GET1: begin
                if (w_press) begin
                    w_word_nx[nibble_lsb(1) +: NIB_W] = i_sw;
                    w_state_nx = ST_GET2;
                end else begin
                    w_state_nx = ST_GET1;
                end
            end
            ST_GET2: begin
                if (w_press) begin
                    w_word_nx[nibble_lsb(2) +: NIB_W] = i_sw;
                    w_state_nx = ST_GET3;
                end else begin
                    w_state_nx = ST_GET2;
                end
            end
            ST_GET3: begin
                if (w_press) begin
                    w_word_nx[nibble_lsb(3) +: NIB_W] = i_sw;
                    w_state_nx = ST_ISSUE;
                end else begin
                    w_state_nx = ST_GET3;
                end
            end
            ST_ISSUE: begin
                if (r_cmd_valid && i_cmd_ready) begin
                    w_state_nx = ST_WAIT;
                    w_wdog_nx  = {WD_W{1'b0}};
                end else begin
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A result arriving on the last watchdog cycle still counts
                if (i_res_valid) begin
                    w_state_nx  = ST_DONE;
                    w_result_nx = i_res_data;
                end else if (r_wdog == WD_LAST) begin
                    w_state_nx  = ST_ERR;
                    w_result_nx = ERR_DISP;
                end else begin
                    w_state_nx = ST_WAIT;
                    w_wdog_nx  = r_wdog + WD_W'(1);
                end
            end
            ST_DONE, ST_ERR: begin
                if (w_press) begin
                    w_state_nx  = ST_IDLE;
                    w_word_nx   = {CMD_W{1'b0}};
                    w_result_nx = 8'h00;
                end else begin
                    w_state_nx = r_state;
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_word_nx   = {CMD_W{1'b0}};
                w_result_nx = 8'h00;
            end
        endcase
    end

    // Output values for the state being entered, so every output is a flop
    always_comb begin
        w_valid_nx = 1'b0;
        w_led_nx   = LED_IDLE;
        w_disp_nx  = 8'h00;
        case (w_state_nx)
            ST_IDLE: begin
                w_led_nx  = LED_IDLE;
                w_disp_nx = 8'h00;
            end
            ST_GET0: begin
                w_led_nx  = LED_ENTER;
                w_disp_nx = {4'd0, i_sw};
            end
            ST_GET1: begin
                w_led_nx  = LED_ENTER;
                w_disp_nx = {4'd1, i_sw};
            end
            ST_GET2: begin
                w_led_nx  = LED_ENTER;
                w_disp_nx = {4'd2, i_sw};
            end
            ST_GET3: begin
                w_led_nx  = LED_ENTER;
                w_disp_nx = {4'd3, i_sw};
            end
            ST_ISSUE: begin
                w_valid_nx = 1'b1;
                w_led_nx   = LED_BUSY;
            end
            ST_WAIT: begin
                w_led_nx = LED_BUSY;
            end
            ST_DONE: begin
                w_led_nx  = LED_DONE;
                w_disp_nx = w_result_nx;
            end
            ST_ERR: begin
                w_led_nx  = LED_ERR;
                w_disp_nx = w_result_nx;
            end
            default: begin
                w_led_nx  = LED_IDLE;
                w_disp_nx = 8'h00;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight command
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cmd_word  <= {CMD_W{1'b0}};
            r_cmd_valid <= 1'b0;
            r_wdog      <= {WD_W{1'b0}};
            r_led       <= LED_IDLE;
            r_disp_hi   <= 4'h0;
            r_disp_lo   <= 4'h0;
        end else begin
            r_state     <= w_state_nx;
            r_cmd_word  <= w_word_nx;
            r_cmd_valid <= w_valid_nx;
            r_wdog      <= w_wdog_nx;
            r_led       <= w_led_nx;
            r_disp_hi   <= w_disp_nx[7:4];
            r_disp_lo   <= w_disp_nx[3:0];
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_word  = r_cmd_word;
    assign o_led       = r_led;
    assign o_disp_hi   = r_disp_hi;
    assign o_disp_lo   = r_disp_lo;

endmodule

// File: tb/tb_mpu_cmd_sequencer.sv
module tb_mpu_cmd_sequencer;

    localparam int D  = 2;
    localparam int TO = 16;

    localparam int M_IDLE  = 0;
    localparam int M_GET   = 1;
    localparam int M_ISSUE = 2;
    localparam int M_WAIT  = 3;
    localparam int M_DONE  = 4;
    localparam int M_ERR   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        enter;
    logic [3:0]  sw;
    logic        cmd_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic [3:0]  led;
    logic [3:0]  disp_hi;
    logic [3:0]  disp_lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] nibs;
        int          ready_delay;
        int          res_delay;   // -1: datapath never answers
        logic [7:0]  res_data;
        logic [15:0] exp_word;
        logic [3:0]  exp_led;
        logic [7:0]  exp_disp;
    } vec_t;

    vec_t tbl[5];

    // Reference model: command progress, collected nibbles, enter history
    int         md;
    int         got;
    int         waited;
    logic [3:0] nib[4];
    logic [7:0] shown;
    logic [7:0] m_disp;
    bit         hist[$];

    always #5 clk = ~clk;

    mpu_cmd_sequencer #(
        .DEB_CYCLES (D),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enter     (enter),
        .i_sw        (sw),
        .o_cmd_valid (cmd_valid),
        .i_cmd_ready (cmd_ready),
        .o_cmd_word  (cmd_word),
        .i_res_valid (res_valid),
        .i_res_data  (res_data),
        .o_led       (led),
        .o_disp_hi   (disp_hi),
        .o_disp_lo   (disp_lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        md     = M_IDLE;
        got    = 0;
        waited = 0;
        foreach (nib[i]) nib[i] = 4'h0;
        shown  = 8'h00;
        m_disp = 8'h00;
        hist.delete();
        repeat (D + 4) hist.push_back(1'b0);
    endfunction

    // A press is seen at an edge when the enter samples taken 3..D+2 edges
    // earlier were all high and the one before them was low.
    function automatic bit model_press();
        int n  = hist.size();
        bit ok = 1'b1;
        for (int j = 0; j < D; j++) begin
            if (!hist[n - 3 - j]) ok = 1'b0;
        end
        if (hist[n - 3 - D]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] led_of(input int m);
        case (m)
            M_GET:          return 4'b0001;
            M_ISSUE, M_WAIT: return 4'b0010;
            M_DONE:         return 4'b0100;
            M_ERR:          return 4'b1000;
            default:        return 4'b0000;
        endcase
    endfunction

    function automatic void model_step();
        bit p;
        if (rst) begin
            model_reset();
        end else begin
            p = model_press();
            hist.push_back(enter);
            if (hist.size() > 64) void'(hist.pop_front());
            case (md)
                M_IDLE: if (p) begin md = M_GET; got = 0; end
                M_GET: if (p) begin
                    nib[got] = sw;
                    got++;
                    if (got == 4) md = M_ISSUE;
                end
                M_ISSUE: if (cmd_ready) begin md = M_WAIT; waited = 0; end
                M_WAIT: begin
                    waited++;
                    if (res_valid) begin
                        md = M_DONE; shown = res_data;
                    end else if (waited == TO) begin
                        md = M_ERR; shown = 8'hEE;
                    end
                end
                M_DONE, M_ERR: if (p) begin
                    md = M_IDLE; shown = 8'h00;
                    foreach (nib[i]) nib[i] = 4'h0;
                end
                default: md = M_IDLE;
            endcase
            if (md == M_GET) m_disp = {4'(got), sw};
            else if (md == M_DONE || md == M_ERR) m_disp = shown;
            else m_disp = 8'h00;
        end
    endfunction

    task automatic tick();
        logic [28:0] exp_v;
        @(posedge clk);
        model_step();
        #1;
        exp_v = {(md == M_ISSUE), nib[0], nib[1], nib[2], nib[3], led_of(md), m_disp};
        chk("cycle", 32'({cmd_valid, cmd_word, led, disp_hi, disp_lo}), 32'(exp_v));
    endtask

    task automatic do_press(input int hold);
        enter = 1'b1;
        repeat (hold) tick();
        enter = 1'b0;
        repeat (D + 4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(cmd_valid), 32'(1'b0));
        chk("async_rst_word",  32'(cmd_word),  32'(16'h0000));
        chk("async_rst_led",   32'(led),       32'(4'b0000));
        chk("async_rst_disp",  32'({disp_hi, disp_lo}), 32'(8'h00));
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic enter_cmd(input logic [15:0] nibs);
        sw = 4'h9;
        do_press(D);
        for (int k = 0; k < 4; k++) begin
            sw = nibs[15 - 4*k -: 4];
            do_press(D);
        end
    endtask

    task automatic run_vec(input vec_t v);
        enter_cmd(v.nibs);
        chk("vec_word",  32'(cmd_word),  32'(v.exp_word));
        chk("vec_valid", 32'(cmd_valid), 32'(1'b1));
        chk("vec_led_busy", 32'(led),    32'(4'b0010));
        for (int i = 0; i < v.ready_delay; i++) begin
            tick();
            chk("hold_valid", 32'(cmd_valid), 32'(1'b1));
            chk("hold_word",  32'(cmd_word),  32'(v.exp_word));
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("accept_valid_drop", 32'(cmd_valid), 32'(1'b0));
        if (v.res_delay < 0) begin
            repeat (TO - 1) tick();
            chk("wd_not_yet", 32'(led), 32'(4'b0010));
            tick();
            chk("wd_expire", 32'(led), 32'(4'b1000));
        end else begin
            repeat (v.res_delay - 1) tick();
            res_valid = 1'b1;
            res_data  = v.res_data;
            tick();
            res_valid = 1'b0;
        end
        tick();
        chk("vec_led",  32'(led), 32'(v.exp_led));
        chk("vec_disp", 32'({disp_hi, disp_lo}), 32'(v.exp_disp));
        do_press(D);
        chk("back_idle_led",  32'(led), 32'(4'b0000));
        chk("back_idle_disp", 32'({disp_hi, disp_lo}), 32'(8'h00));
        chk("back_idle_word", 32'(cmd_word), 32'(16'h0000));
    endtask

    initial begin
        bit lvl;
        int run_left;

        tbl[0] = '{16'h10A5, 5, 2,   8'h3C, 16'h10A5, 4'b0100, 8'h3C};
        tbl[1] = '{16'h10C3, 0, 1,   8'h5A, 16'h10C3, 4'b0100, 8'h5A};
        tbl[2] = '{16'hFEDC, 2, -1,  8'h00, 16'hFEDC, 4'b1000, 8'hEE};
        tbl[3] = '{16'h0001, 1, TO,  8'hA7, 16'h0001, 4'b0100, 8'hA7};
        tbl[4] = '{16'h7392, 3, TO-1, 8'h00, 16'h7392, 4'b0100, 8'h00};

        rst = 1'b1; enter = 1'b0; sw = 4'h0;
        cmd_ready = 1'b0; res_valid = 1'b0; res_data = 8'h00;
        model_reset();
        #20;
        rst = 1'b0;
        chk("rst_valid", 32'(cmd_valid), 32'(1'b0));
        chk("rst_word",  32'(cmd_word),  32'(16'h0000));
        chk("rst_led",   32'(led),       32'(4'b0000));
        chk("rst_disp",  32'({disp_hi, disp_lo}), 32'(8'h00));

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // High shorter than the debounce length is ignored
        enter = 1'b1;
        repeat (D - 1) tick();
        enter = 1'b0;
        repeat (8) tick();
        chk("short_pulse_led", 32'(led), 32'(4'b0000));

        // A long hold yields exactly one press
        enter = 1'b1;
        repeat (50) tick();
        enter = 1'b0;
        repeat (6) tick();
        chk("long_hold_led",  32'(led),     32'(4'b0001));
        chk("long_hold_digit", 32'(disp_hi), 32'(4'h0));
        do_reset();

        // Reset while in GET2 after capturing 1,0
        do_press(D);
        sw = 4'h1; do_press(D);
        sw = 4'h0; do_press(D);
        chk("get2_digit", 32'(disp_hi),  32'(4'h2));
        chk("get2_word",  32'(cmd_word), 32'(16'h1000));
        do_reset();
        run_vec(tbl[1]);

        // Reset while a command is being offered
        enter_cmd(16'h2468);
        chk("issue_valid", 32'(cmd_valid), 32'(1'b1));
        do_reset();

        // Stray result in IDLE, presses during WAIT
        res_valid = 1'b1; res_data = 8'hFF;
        tick();
        res_valid = 1'b0;
        tick();
        chk("stray_res_led",  32'(led), 32'(4'b0000));
        chk("stray_res_disp", 32'({disp_hi, disp_lo}), 32'(8'h00));
        enter_cmd(16'h5111);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        do_press(D);
        chk("wait_press_led", 32'(led), 32'(4'b0010));
        res_valid = 1'b1; res_data = 8'h42;
        tick();
        res_valid = 1'b0;
        chk("wait_press_done", 32'(led), 32'(4'b0100));
        chk("wait_press_disp", 32'({disp_hi, disp_lo}), 32'(8'h42));
        do_press(D);

        // Randomized traffic against the reference model
        lvl = 1'b0;
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                lvl = ~lvl;
                run_left = int'($urandom_range(1, 6));
            end
            run_left--;
            enter     = lvl;
            sw        = 4'($urandom_range(0, 15));
            cmd_ready = ($urandom_range(0, 1) == 1);
            res_valid = ($urandom_range(0, 9) == 0);
            res_data  = 8'($urandom_range(0, 255));
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
